// File: rtl/video_cmd_issuer_if.sv
// NASTI-lite channel bundle (64-bit address, 32-bit data) carrying only the
// AW/W/B/AR/R signals the command issuer needs.
interface nasti_channel;
  logic [63:0] aw_addr;
  logic [2:0]  aw_prot;
  logic        aw_valid;
  logic        aw_ready;
  logic [31:0] w_data;
  logic [3:0]  w_strb;
  logic        w_valid;
  logic        w_ready;
  logic [1:0]  b_resp;
  logic        b_valid;
  logic        b_ready;
  logic [63:0] ar_addr;
  logic [2:0]  ar_prot;
  logic        ar_valid;
  logic        ar_ready;
  logic [31:0] r_data;
  logic [1:0]  r_resp;
  logic        r_valid;
  logic        r_ready;

  modport master (
    output aw_addr, aw_prot, aw_valid, input aw_ready,
    output w_data, w_strb, w_valid, input w_ready,
    input b_resp, b_valid, output b_ready,
    output ar_addr, ar_prot, ar_valid, input ar_ready,
    input r_data, r_resp, r_valid, output r_ready
  );

  modport slave (
    input aw_addr, aw_prot, aw_valid, output aw_ready,
    input w_data, w_strb, w_valid, output w_ready,
    output b_resp, b_valid, input b_ready,
    input ar_addr, ar_prot, ar_valid, output ar_ready,
    output r_data, r_resp, r_valid, input r_ready
  );
endinterface

// File: rtl/video_cmd_issuer.sv
// Pushes 64-bit DataMover commands into one of two remote command FIFOs as
// low/high 32-bit NASTI-lite writes, polling FIFO occupancy when out of credit.
module video_cmd_issuer #(
  parameter logic [63:0] BASE_ADDR = 64'h0,
  parameter int          FIFO_CAP  = 128,
  parameter int          OCC_WIDTH = 8
) (
  input  logic          aclk,
  input  logic          aresetn,
  input  logic          cmd_valid,
  output logic          cmd_ready,
  input  logic [63:0]   cmd_data,
  input  logic          cmd_sel,
  output logic          cmd_done,
  output logic          err,
  nasti_channel.master  m_nasti
);

  localparam int CW = $clog2(FIFO_CAP) + 1;

  typedef enum logic [2:0] {
    IDLE, POLL_AR, POLL_R, LO_AW_W, LO_B, HI_AW_W, HI_B
  } state_t;

  state_t               state, state_nxt;
  logic [63:0]          cmd_q;
  logic                 sel_q;
  logic [CW-1:0]        credit [2];
  logic                 aw_done, w_done;
  logic                 cmd_hs, aw_hs, w_hs, b_hs, ar_hs, r_hs, pair_done;
  logic [OCC_WIDTH-1:0] occ;
  logic [CW-1:0]        fresh_credit;
  logic [63:0]          win_addr;
  logic                 in_aw_w, in_hi;

  assign cmd_hs    = cmd_valid && cmd_ready;
  assign aw_hs     = m_nasti.aw_valid && m_nasti.aw_ready;
  assign w_hs      = m_nasti.w_valid && m_nasti.w_ready;
  assign b_hs      = m_nasti.b_valid && m_nasti.b_ready;
  assign ar_hs     = m_nasti.ar_valid && m_nasti.ar_ready;
  assign r_hs      = m_nasti.r_valid && m_nasti.r_ready;
  // AW and W complete independently; the pair is done once both have landed.
  assign pair_done = (aw_done || aw_hs) && (w_done || w_hs);
  assign win_addr  = BASE_ADDR + (sel_q ? 64'd8 : 64'd0);
  assign in_aw_w   = (state == LO_AW_W) || (state == HI_AW_W);
  assign in_hi     = (state == HI_AW_W) || (state == HI_B);
  assign occ       = m_nasti.r_data[OCC_WIDTH-1:0];

  generate
    if (OCC_WIDTH < 32) begin : g_rdata_hi
      logic unused_rdata;
      assign unused_rdata = ^m_nasti.r_data[31:OCC_WIDTH];
    end
  endgenerate

  // Free slots reported by the remote FIFO, clamped at zero on over-report.
  always_comb begin
    if (32'(occ) > FIFO_CAP) fresh_credit = '0;
    else                     fresh_credit = CW'(FIFO_CAP - 32'(occ));
  end

  // NOTE: non-blocking (<=) on every flop so all registers update together at the edge.
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) state <= IDLE;
    else          state <= state_nxt;
  end

  // NOTE: default assignment first so no branch can leave a latch behind.
  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:    if (cmd_hs)    state_nxt = (credit[cmd_sel] != '0) ? LO_AW_W : POLL_AR;
      POLL_AR: if (ar_hs)     state_nxt = POLL_R;
      POLL_R:  if (r_hs)      state_nxt = (fresh_credit != '0) ? LO_AW_W : POLL_AR;
      LO_AW_W: if (pair_done) state_nxt = LO_B;
      LO_B:    if (b_hs)      state_nxt = HI_AW_W;
      HI_AW_W: if (pair_done) state_nxt = HI_B;
      HI_B:    if (b_hs)      state_nxt = IDLE;
      default:                state_nxt = IDLE;
    endcase
  end

  always_comb begin
    cmd_ready        = aresetn && (state == IDLE) && !cmd_done;
    m_nasti.aw_valid = in_aw_w && !aw_done;
    m_nasti.w_valid  = in_aw_w && !w_done;
    m_nasti.aw_addr  = win_addr + (in_hi ? 64'd4 : 64'd0);
    m_nasti.aw_prot  = 3'b000;
    m_nasti.w_data   = in_hi ? cmd_q[63:32] : cmd_q[31:0];
    m_nasti.w_strb   = 4'hF;
    m_nasti.b_ready  = (state == LO_B) || (state == HI_B);
    m_nasti.ar_valid = (state == POLL_AR);
    m_nasti.ar_addr  = win_addr;
    m_nasti.ar_prot  = 3'b000;
    m_nasti.r_ready  = (state == POLL_R);
  end

  // NOTE: payload register has no reset; it is only read after being loaded.
  always_ff @(posedge aclk) begin
    if (cmd_hs) cmd_q <= cmd_data;
  end

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      sel_q     <= 1'b0;
      credit[0] <= '0;
      credit[1] <= '0;
      aw_done   <= 1'b0;
      w_done    <= 1'b0;
      cmd_done  <= 1'b0;
      err       <= 1'b0;
    end else begin
      cmd_done <= (state == HI_B) && b_hs;
      if (cmd_hs) sel_q <= cmd_sel;
      if ((state == POLL_R) && r_hs) credit[sel_q] <= fresh_credit;
      if ((state == HI_B) && b_hs && (credit[sel_q] != '0))
        credit[sel_q] <= credit[sel_q] - CW'(1);
      if (pair_done) begin
        aw_done <= 1'b0;
        w_done  <= 1'b0;
      end else begin
        if (aw_hs) aw_done <= 1'b1;
        if (w_hs)  w_done  <= 1'b1;
      end
      // Error responses are recorded but never break the low/high pairing.
      if ((r_hs && (m_nasti.r_resp != 2'b00)) || (b_hs && (m_nasti.b_resp != 2'b00)))
        err <= 1'b1;
    end
  end

endmodule
